// File: rtl/dkong3_audio_pkg.sv
//------------------------------------------------------------------------------
// dkong3_audio_pkg - shared types and helpers for the audio output path. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dkong3_audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HP   = 2'd1,
    LP   = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam int FRAC_W = 8;
  localparam int SAT_W  = 28;

  localparam logic signed [SAT_W-1:0] SAT_MAX = 28'sd32767;
  localparam logic signed [SAT_W-1:0] SAT_MIN = -28'sd32768;

  function automatic logic signed [15:0] sat16(input logic signed [SAT_W-1:0] v);
    logic signed [15:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[15:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[15:0];
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dkong3_audio_out.sv
//------------------------------------------------------------------------------
// dkong3_audio_out - box-car decimator, DC blocker, low-pass, volume, limiter. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dkong3_audio_out
  import dkong3_audio_pkg::*;
#(
  parameter int DIV_LOG2 = 9,
  parameter int HP_SHIFT = 10,
  parameter int LP_SHIFT = 2
) (
  input  logic               I_CLK_24M,
  input  logic               I_RESETn,
  input  logic signed [15:0] I_SAMPLE,
  input  logic        [1:0]  I_VOL,
  input  logic               I_MUTE,
  output logic signed [15:0] O_SAMPLE,
  output logic               O_STROBE
);

  localparam int ACC_W = 16 + DIV_LOG2;
  localparam int HP_W  = 26;

  logic        [DIV_LOG2-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [15:0]         x_reg_q, x_reg_d;
  logic signed [15:0]         x_prev_q, x_prev_d;
  logic signed [HP_W-1:0]     hp_q, hp_d;
  logic signed [HP_W-1:0]     lp_q, lp_d;
  logic signed [15:0]         sample_q, sample_d;
  logic                       strobe_q, strobe_d;
  state_e                     state_q, state_d;

  logic                       tick;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [SAT_W-1:0]    x_e, xp_e, hp_e, lp_e;
  logic signed [SAT_W-1:0]    hp_next, lp_next, v_e;
  logic                       unused_headroom;

  // Filter arithmetic runs at 28 bits so nothing wraps before the limiter.
  always_comb begin
    tick    = &cnt_q;
    acc_sum = acc_q + ACC_W'(I_SAMPLE);
    x_e     = SAT_W'(x_reg_q);
    xp_e    = SAT_W'(x_prev_q);
    hp_e    = SAT_W'(hp_q);
    lp_e    = SAT_W'(lp_q);
    hp_next = ((x_e - xp_e) <<< FRAC_W) + hp_e - (hp_e >>> HP_SHIFT);
    lp_next = lp_e + ((hp_e - lp_e) >>> LP_SHIFT);
    v_e     = (lp_e >>> FRAC_W) >>> I_VOL;
  end

  assign unused_headroom = ^{hp_next[SAT_W-1:HP_W], lp_next[SAT_W-1:HP_W]};

  always_comb begin
    cnt_d    = cnt_q + DIV_LOG2'(1);
    acc_d    = acc_sum;
    x_reg_d  = x_reg_q;
    x_prev_d = x_prev_q;
    hp_d     = hp_q;
    lp_d     = lp_q;
    sample_d = sample_q;
    strobe_d = 1'b0;
    state_d  = state_q;

    if (tick) begin
      x_reg_d = 16'(acc_sum >>> DIV_LOG2);
      acc_d   = '0;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = HP;
        end
      end
      HP: begin
        hp_d     = hp_next[HP_W-1:0];
        x_prev_d = x_reg_q;
        state_d  = LP;
      end
      LP: begin
        lp_d    = lp_next[HP_W-1:0];
        state_d = OUT;
      end
      OUT: begin
        sample_d = I_MUTE ? '0 : sat16(v_e);
        strobe_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      x_reg_q  <= '0;
      x_prev_q <= '0;
      hp_q     <= '0;
      lp_q     <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
      state_q  <= IDLE;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      x_reg_q  <= x_reg_d;
      x_prev_q <= x_prev_d;
      hp_q     <= hp_d;
      lp_q     <= lp_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
      state_q  <= state_d;
    end
  end

  assign O_SAMPLE = sample_q;
  assign O_STROBE = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_dkong3_audio_out.sv
//------------------------------------------------------------------------------
// tb_dkong3_audio_out - scoreboard bench for two instances (LP_SHIFT 2 and 0). Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dkong3_audio_out;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] samp = 16'sd1234;
  logic        [1:0]  vol = 2'd0;
  logic               mute = 1'b0;
  logic signed [15:0] out_a, out_b;
  logic               stb_a, stb_b;

  always #5 clk = ~clk;

  dkong3_audio_out dut (
    .I_CLK_24M (clk),
    .I_RESETn  (rst_n),
    .I_SAMPLE  (samp),
    .I_VOL     (vol),
    .I_MUTE    (mute),
    .O_SAMPLE  (out_a),
    .O_STROBE  (stb_a)
  );

  dkong3_audio_out #(.LP_SHIFT(0)) dut_b (
    .I_CLK_24M (clk),
    .I_RESETn  (rst_n),
    .I_SAMPLE  (samp),
    .I_VOL     (vol),
    .I_MUTE    (mute),
    .O_SAMPLE  (out_b),
    .O_STROBE  (stb_b)
  );

  typedef struct {
    logic signed [15:0] val;
    int                 due;
  } exp_t;

  exp_t   q_a[$];
  exp_t   q_b[$];
  exp_t   mon_a, mon_b;
  int     total = 0;
  int     bad = 0;
  int     edge_n = 0;
  int     n_strobe_a = 0;
  int     n_strobe_b = 0;

  int     m_cnt = 0;
  longint m_acc = 0, m_xprev = 0, m_hp = 0, m_lp_a = 0, m_lp_b = 0;

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_acc = 0; m_xprev = 0; m_hp = 0; m_lp_a = 0; m_lp_b = 0;
    edge_n = 0;
    q_a.delete();
    q_b.delete();
  endtask

  // Reference: window average, then the filter chain evaluated at the tick.
  task automatic model_edge(input logic signed [15:0] s);
    longint sum, x, va, vb;
    exp_t   e;
    edge_n++;
    sum = m_acc + longint'(s);
    if (m_cnt == 511) begin
      x       = sum >>> 9;
      m_acc   = 0;
      m_hp    = ((x - m_xprev) <<< 8) + m_hp - (m_hp >>> 10);
      m_xprev = x;
      m_lp_a  = m_lp_a + ((m_hp - m_lp_a) >>> 2);
      m_lp_b  = m_hp;
      va      = sat((m_lp_a >>> 8) >>> vol);
      vb      = sat((m_lp_b >>> 8) >>> vol);
      e.due   = edge_n + 3;
      e.val   = mute ? 16'sd0 : 16'(va);
      q_a.push_back(e);
      e.val   = mute ? 16'sd0 : 16'(vb);
      q_b.push_back(e);
    end else begin
      m_acc = sum;
    end
    m_cnt = (m_cnt + 1) % 512;
  endtask

  task automatic step(input logic signed [15:0] s);
    samp = s;
    @(posedge clk);
    if (rst_n) model_edge(s);
    else edge_n = 0;
    #1;
  endtask

  task automatic run(input int n, input logic signed [15:0] s);
    repeat (n) step(s);
  endtask

  always @(negedge clk) begin
    if (stb_a) begin
      n_strobe_a++;
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL strobe_a_unexpected edge=%0d sample=%0d", edge_n, out_a);
      end else begin
        mon_a = q_a.pop_front();
        if (out_a !== mon_a.val) begin
          bad++;
          $display("FAIL sample_a got=%0d want=%0d edge=%0d", out_a, mon_a.val, edge_n);
        end
        total++;
        if (edge_n != mon_a.due) begin
          bad++;
          $display("FAIL timing_a got_edge=%0d want_edge=%0d", edge_n, mon_a.due);
        end
      end
    end
    if (stb_b) begin
      n_strobe_b++;
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL strobe_b_unexpected edge=%0d sample=%0d", edge_n, out_b);
      end else begin
        mon_b = q_b.pop_front();
        if (out_b !== mon_b.val || edge_n != mon_b.due) begin
          bad++;
          $display("FAIL sample_b got=%0d@%0d want=%0d@%0d", out_b, edge_n, mon_b.val, mon_b.due);
        end
      end
    end
  end

  // Hold reset for n edges, confirming every register and output is cleared.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_clear();
    repeat (n) step(samp);
    total++;
    if (out_a !== 16'sd0 || stb_a !== 1'b0 || out_b !== 16'sd0 || stb_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got a=%0d/%b b=%0d/%b want 0/0", out_a, stb_a, out_b, stb_b);
    end
    total++;
    if (dut.cnt_q !== '0 || dut.acc_q !== '0 || dut.x_reg_q !== '0 || dut.x_prev_q !== '0 ||
        dut.hp_q !== '0 || dut.lp_q !== '0 || dut.state_q !== dkong3_audio_pkg::IDLE) begin
      bad++;
      $display("FAIL reset_regs got hp=%0d lp=%0d acc=%0d cnt=%0d want all 0",
               dut.hp_q, dut.lp_q, dut.acc_q, dut.cnt_q);
    end
    rst_n = 1'b1;
  endtask

  task automatic check_drained(input string nm);
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_strobe pending_a=%0d pending_b=%0d want 0", nm, q_a.size(), q_b.size());
    end
  endtask

  task automatic check_out(input string nm, input logic signed [15:0] got, input logic s,
                           input logic signed [15:0] want);
    total++;
    if (s !== 1'b1 || got !== want) begin
      bad++;
      $display("FAIL %s got=%0d strobe=%b want=%0d strobe=1", nm, got, s, want);
    end
  endtask

  task automatic test_reset();
    vol = 2'd0; mute = 1'b0;
    samp = 16'sd1234;
    do_reset(4);
    run(514, 16'sd1234);
    total++;
    if (stb_a !== 1'b0 || n_strobe_a != 0) begin
      bad++;
      $display("FAIL reset_early_strobe got=%b count=%0d want 0", stb_a, n_strobe_a);
    end
    step(16'sd1234);
    check_out("reset_first_strobe", out_a, stb_a, 16'sd308);
    run(8, 16'sd1234);
    check_drained("reset");
  endtask

  task automatic test_dc_step();
    do_reset(2);
    run(515, 16'sd1000);
    check_out("dc_first_a", out_a, stb_a, 16'sd250);
    check_out("dc_first_b", out_b, stb_b, 16'sd1000);
    run(512, 16'sd1000);
    check_out("dc_second_a", out_a, stb_a, 16'sd437);
    run(512, 16'sd1000);
    check_out("dc_third_a", out_a, stb_a, 16'sd577);
    run(520, 16'sd1000);
    check_drained("dc_step");
  endtask

  task automatic test_volume();
    do_reset(2);
    vol = 2'd2;
    run(515, 16'sd1000);
    check_out("vol2", out_a, stb_a, 16'sd62);
    run(8, 16'sd1000);
    do_reset(2);
    vol = 2'd3;
    run(515, 16'sd1000);
    check_out("vol3", out_a, stb_a, 16'sd31);
    run(8, 16'sd1000);
    vol = 2'd0;
    check_drained("volume");
  endtask

  task automatic test_saturation();
    do_reset(2);
    run(512, -16'sd32768);
    run(515, 16'sd32767);
    check_out("sat_pos", out_b, stb_b, 16'sd32767);
    run(8, 16'sd32767);
    do_reset(2);
    run(512, 16'sd32767);
    run(515, -16'sd32768);
    check_out("sat_neg", out_b, stb_b, -16'sd32768);
    run(8, -16'sd32768);
    check_drained("saturation");
  endtask

  task automatic test_mute();
    int s0;
    do_reset(2);
    s0 = n_strobe_a;
    mute = 1'b1;
    run(515, 16'sd1000);
    check_out("mute_first", out_a, stb_a, 16'sd0);
    run(515, 16'sd1000);
    mute = 1'b0;
    run(509, 16'sd1000);
    check_out("mute_release_w3", out_a, stb_a, 16'sd577);
    run(8, 16'sd1000);
    total++;
    if (n_strobe_a - s0 != 3) begin
      bad++;
      $display("FAIL mute_strobe_count got=%0d want=3", n_strobe_a - s0);
    end
    check_drained("mute");
  endtask

  task automatic test_reset_mid();
    int s0;
    do_reset(2);
    run(512, 16'sd700);
    do_reset(1);
    s0 = n_strobe_a;
    run(514, 16'sd700);
    total++;
    if (n_strobe_a != s0 || stb_a !== 1'b0) begin
      bad++;
      $display("FAIL midreset_aborted got_count=%0d strobe=%b want_count=%0d", n_strobe_a, stb_a, s0);
    end
    step(16'sd700);
    check_out("midreset_restart", out_a, stb_a, 16'sd175);
    run(8, 16'sd700);
    check_drained("reset_mid");
  endtask

  task automatic test_back_to_back();
    int s0;
    logic signed [15:0] r;
    do_reset(2);
    s0 = n_strobe_a;
    for (int w = 0; w < 8; w++) begin
      for (int c = 0; c < 512; c++) begin
        if (c == 100) begin
          vol  = 2'($urandom_range(0, 3));
          mute = ($urandom_range(0, 7) == 0);
        end
        r = 16'($urandom);
        step(r);
      end
    end
    run(8, 16'sd0);
    total++;
    if (n_strobe_a - s0 != 8) begin
      bad++;
      $display("FAIL back_to_back_count got=%0d want=8", n_strobe_a - s0);
    end
    check_drained("back_to_back");
    vol = 2'd0; mute = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dc_step();
    test_volume();
    test_saturation();
    test_mute();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
